// File: rtl/game_engine_pkg.sv
// Shared definitions for the pong-style game engine: display word layout,
// FSM states and paddle limits.
package game_engine_pkg;

  localparam int FIELD_W    = 3;
  localparam int WORD_W     = 4 * FIELD_W;
  localparam int PAD1_LSB   = 9;
  localparam int PAD2_LSB   = 6;
  localparam int BALL_X_LSB = 3;
  localparam int BALL_Y_LSB = 0;

  typedef logic [FIELD_W-1:0] coord_t;

  localparam coord_t PAD_MIN = 3'd1;
  localparam coord_t PAD_MAX = 3'd6;
  localparam coord_t CENTRE  = 3'd3;

  typedef enum logic [1:0] {
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  // One paddle step: move only on a single pressed button, never past the limits.
  function automatic coord_t paddle_step(input coord_t c, input logic up, input logic dn);
    paddle_step = c;
    if (up && !dn && (c > PAD_MIN))      paddle_step = c - 3'd1;
    else if (dn && !up && (c < PAD_MAX)) paddle_step = c + 3'd1;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game tick generator: one-cycle tick pulse every TICK_DIV clkin cycles.
module game_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clkin,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/game_engine.sv
// Game engine top: paddles, ball physics, scoring and the serve/play/point/over FSM,
// all advanced once per game tick.
module game_engine
  import game_engine_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int WIN_SCORE  = 5,
  parameter int SERVE_HOLD = 2
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              p1_up,
  input  logic              p1_dn,
  input  logic              p2_up,
  input  logic              p2_dn,
  input  logic              start,
  output logic [WORD_W-1:0] in_word,
  output logic [FIELD_W-1:0] score1,
  output logic [FIELD_W-1:0] score2,
  output logic              game_over
);

  localparam int     HW        = (SERVE_HOLD > 1) ? $clog2(SERVE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SERVE_HOLD - 1);
  localparam coord_t WIN       = coord_t'(WIN_SCORE);

  logic tick;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clkin (clkin),
    .rst   (rst),
    .tick  (tick)
  );

  state_t        state_q, state_d;
  coord_t        p1_q, p1_d, p2_q, p2_d;
  coord_t        bx_q, bx_d, by_q, by_d;
  coord_t        s1_q, s1_d, s2_q, s2_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic          over_q, over_d;
  logic [HW-1:0] hold_q, hold_d;

  // Scratch terms of the PLAY move
  coord_t ny, pc;
  logic   ndy, at_p1, at_p2, hit;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= ST_SERVE;
      p1_q    <= CENTRE;
      p2_q    <= CENTRE;
      bx_q    <= CENTRE;
      by_q    <= CENTRE;
      s1_q    <= '0;
      s2_q    <= '0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      over_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      over_q  <= over_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    bx_d    = bx_q;
    by_d    = by_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    over_d  = over_q;
    hold_d  = hold_q;
    ny      = by_q;
    ndy     = dy_q;
    at_p1   = (bx_q == 3'd1) && dx_q;
    at_p2   = (bx_q == 3'd6) && !dx_q;
    pc      = at_p1 ? p1_q : p2_q;
    hit     = 1'b0;

    if (tick) begin
      if (state_q != ST_OVER) begin
        p1_d = paddle_step(p1_q, p1_up, p1_dn);
        p2_d = paddle_step(p2_q, p2_up, p2_dn);
      end

      unique case (state_q)
        ST_SERVE: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_PLAY;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        ST_PLAY: begin
          // Wall bounce: reflect the row instead of leaving 0..7
          if (!dy_q) begin
            if (by_q == 3'd7) begin ny = 3'd6; ndy = 1'b1; end
            else              ny = by_q + 3'd1;
          end else begin
            if (by_q == 3'd0) begin ny = 3'd1; ndy = 1'b0; end
            else              ny = by_q - 3'd1;
          end
          by_d = ny;
          dy_d = ndy;
          // Paddle check uses the pre-tick paddle centre
          hit  = (ny >= pc - 3'd1) && (ny <= pc + 3'd1);
          if ((at_p1 || at_p2) && hit) begin
            dx_d = ~dx_q;
            bx_d = at_p1 ? 3'd2 : 3'd5;
          end else begin
            bx_d = dx_q ? (bx_q - 3'd1) : (bx_q + 3'd1);
            if (at_p1) begin
              if (s2_q < WIN) s2_d = s2_q + 3'd1;
              state_d = ST_POINT;
            end else if (at_p2) begin
              if (s1_q < WIN) s1_d = s1_q + 3'd1;
              state_d = ST_POINT;
            end
          end
        end

        ST_POINT: begin
          // dx still points at the loser, which is the next serve direction
          if ((s1_q == WIN) || (s2_q == WIN)) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = ST_SERVE;
            bx_d    = CENTRE;
            by_d    = CENTRE;
          end
        end

        ST_OVER: begin
          if (start) begin
            state_d = ST_SERVE;
            over_d  = 1'b0;
            s1_d    = '0;
            s2_d    = '0;
            dx_d    = 1'b0;
            dy_d    = 1'b0;
            bx_d    = CENTRE;
            by_d    = CENTRE;
          end
        end
      endcase
    end
  end

  always_comb begin
    in_word = '0;
    in_word[PAD1_LSB   +: FIELD_W] = p1_q;
    in_word[PAD2_LSB   +: FIELD_W] = p2_q;
    in_word[BALL_X_LSB +: FIELD_W] = bx_q;
    in_word[BALL_Y_LSB +: FIELD_W] = by_q;
  end

  assign score1    = s1_q;
  assign score2    = s2_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_game_engine.sv
// Self-checking bench for game_engine: directed opening plus random play checked
// every cycle against a velocity-based behavioural model.
module tb_game_engine;

  localparam int TICK_DIV   = 4;
  localparam int WIN_SCORE  = 2;
  localparam int SERVE_HOLD = 2;

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0, start = 1'b0;
  logic [11:0] in_word;
  logic [2:0]  score1, score2;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;
  bit saw_over = 0;
  bit saw_restart = 0;
  int n_points = 0;

  game_engine #(
    .TICK_DIV   (TICK_DIV),
    .WIN_SCORE  (WIN_SCORE),
    .SERVE_HOLD (SERVE_HOLD)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .p1_up     (p1_up),
    .p1_dn     (p1_dn),
    .p2_up     (p2_up),
    .p2_dn     (p2_dn),
    .start     (start),
    .in_word   (in_word),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_cnt, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_serve_left;
  bit  m_point, m_over;

  function automatic int move_pad(input int c, input logic up, input logic dn);
    if (up && !dn) return (c > 1) ? c - 1 : c;
    if (dn && !up) return (c < 6) ? c + 1 : c;
    return c;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_p1 = 3; m_p2 = 3; m_bx = 3; m_by = 3;
    m_vx = 1; m_vy = 1; m_s1 = 0; m_s2 = 0;
    m_serve_left = SERVE_HOLD; m_point = 0; m_over = 0;
  endfunction

  function automatic void model_tick();
    int old1, old2, nx, ny, pc;
    if (m_over) begin
      if (start) begin
        m_over = 0; m_s1 = 0; m_s2 = 0; m_vx = 1; m_vy = 1;
        m_bx = 3; m_by = 3; m_serve_left = SERVE_HOLD;
        saw_restart = 1;
      end
      return;
    end
    old1 = m_p1; old2 = m_p2;
    m_p1 = move_pad(m_p1, p1_up, p1_dn);
    m_p2 = move_pad(m_p2, p2_up, p2_dn);
    if (m_serve_left > 0) begin
      m_serve_left--;
    end else if (m_point) begin
      m_point = 0;
      if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) m_over = 1;
      else begin m_bx = 3; m_by = 3; m_serve_left = SERVE_HOLD; end
    end else begin
      ny = m_by + m_vy;
      if (ny < 0 || ny > 7) begin m_vy = -m_vy; ny = m_by + m_vy; end
      nx = m_bx + m_vx;
      if (nx == 0 || nx == 7) begin
        pc = (nx == 0) ? old1 : old2;
        if (ny >= pc - 1 && ny <= pc + 1) begin
          m_vx = -m_vx; nx = m_bx + m_vx;
        end else begin
          if (nx == 7) m_s1 = (m_s1 < WIN_SCORE) ? m_s1 + 1 : m_s1;
          else         m_s2 = (m_s2 < WIN_SCORE) ? m_s2 + 1 : m_s2;
          m_point = 1;
          n_points++;
        end
      end
      m_bx = nx; m_by = ny;
    end
  endfunction

  always @(posedge clkin or posedge rst) begin
    if (rst) model_reset();
    else if (m_cnt == TICK_DIV - 1) begin
      m_cnt = 0;
      model_tick();
    end else begin
      m_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clkin) begin
    logic [11:0] e;
    if (checking && !rst) begin
      e = {3'(m_p1), 3'(m_p2), 3'(m_bx), 3'(m_by)};
      check("in_word", in_word, e);
      check("score1", {9'd0, score1}, 12'(m_s1));
      check("score2", {9'd0, score2}, 12'(m_s2));
      check("game_over", {11'd0, game_over}, {11'd0, m_over});
      if (game_over) saw_over = 1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clkin);
    check("reset_word", in_word, 12'h6DB);
    check("reset_scores", {6'd0, score1, score2}, 12'd0);
    check("reset_over", {11'd0, game_over}, 12'd0);

    rst = 1'b0;
    checking = 1;
    p1_up = 1'b1;
    @(negedge clkin);
    check("pre_tick_word", in_word, 12'h6DB);
    repeat (3) @(negedge clkin);
    check("tick1_p1_up", in_word, 12'h4DB);
    repeat (4) @(negedge clkin);
    check("tick2_p1_up", in_word, 12'h2DB);
    repeat (4) @(negedge clkin);
    check("tick3_first_move", in_word, 12'h2E4);
    p1_dn = 1'b1;
    repeat (4) @(negedge clkin);
    check("tick4_both_buttons", in_word, 12'h2ED);

    for (int i = 0; i < 6000; i++) begin
      @(negedge clkin);
      p1_up = ($urandom_range(0, 2) == 0);
      p1_dn = ($urandom_range(0, 2) == 0);
      p2_up = ($urandom_range(0, 2) == 0);
      p2_dn = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      if (i == 4000) begin
        #2 rst = 1'b1;
        #1;
        check("midgame_reset_word", in_word, 12'h6DB);
        check("midgame_reset_scores", {6'd0, score1, score2}, 12'd0);
        check("midgame_reset_over", {11'd0, game_over}, 12'd0);
        @(negedge clkin);
        rst = 1'b0;
      end
    end

    check("saw_game_over", {11'd0, saw_over}, 12'd1);
    check("saw_restart", {11'd0, saw_restart}, 12'd1);
    check("saw_points", {11'd0, n_points > 2}, 12'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_engine.md
GAME_ENGINE -- requirements
Module: game_engine

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clkin cycles per game tick (minimum 2).
REQ-002 Parameter WIN_SCORE, default 5, points needed to end the game (range 1..7).
REQ-003 Parameter SERVE_HOLD, default 2, game ticks the ball is held at centre before each serve.
REQ-004 clkin  in  1  system clock; the one clock of the block; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 p1_up, p1_dn  in  1 each  paddle-1 buttons, level, already synchronised to clkin.
REQ-007 p2_up, p2_dn  in  1 each  paddle-2 buttons, level, already synchronised to clkin.
REQ-008 start  in  1  level; restarts the game from GAME_OVER.
REQ-009 in_word  out  12  display word: [11:9] paddle-1 centre, [8:6] paddle-2 centre, [5:3] ball column, [2:0] ball row.
REQ-010 score1, score2  out  3 each  points won by player 1 and player 2.
REQ-011 game_over  out  1  high while in GAME_OVER.

Function
REQ-012 Tick generator: counts 0..TICK_DIV-1 and pulses tick for one clkin cycle at the wrap; all game updates occur only on tick cycles.
REQ-013 Paddle 1 occupies column 0 and paddle 2 occupies column 7; each paddle covers rows centre-1..centre+1, with the centre clamped to 1..6.
REQ-014 On each tick, in every state except GAME_OVER, each paddle moves up (-1) when only up is asserted and down (+1) when only down is asserted; it holds when both or neither are asserted, and holds at the clamp limit.
REQ-015 Ball direction registers: dx (0 = +column, 1 = -column) and dy (0 = +row, 1 = -row); the ball moves one column and one row per PLAY tick.
REQ-016 Wall rule: if the next row would leave 0..7, invert dy and move the row the opposite way (row 7 with dy=0 goes to row 6).
REQ-017 Paddle rule: when the ball is at column 1 with dx=1, or at column 6 with dx=0, the move is checked against the paddle on that side. If the ball's row after the wall rule is within that paddle's span, invert dx and move the column away from the paddle.
REQ-018 Miss: if the paddle rule does not deflect the ball, it enters column 0 or 7; the opposite player's score increments and the FSM goes to POINT.
REQ-019 A corner hit (wall and paddle on the same tick) inverts both dx and dy in the same tick.
REQ-020 FSM states:
  - SERVE: ball at column 3, row 3; after SERVE_HOLD ticks go to PLAY.
  - PLAY: ball moves per REQ-015..REQ-019.
  - POINT: ball frozen for one tick; then go to GAME_OVER if either score equals WIN_SCORE, else to SERVE.
  - GAME_OVER: everything frozen; start sampled on a tick clears scores and goes to SERVE.
REQ-021 Serve direction: toward the player who lost the last point; the first serve after reset or restart uses dx=0, dy=0.
REQ-022 Scores saturate at WIN_SCORE and never wrap.
REQ-023 in_word, score1, score2 and game_over are registered; they change only on the clkin edge that ends a tick cycle, so latency is exactly one clkin cycle after tick.
REQ-024 Paddle and ball updates within one tick use the paddle positions from before that tick.

Reset
REQ-025 While rst is high:
  - in_word = 12'b011_011_011_011 (paddles, ball column and row all 3);
  - scores = 0; game_over = 0; dx = dy = 0;
  - FSM = SERVE; tick counter = 0.
REQ-026 Reset asserted mid-game or mid-tick aborts immediately with no partial update; the first tick after release arrives TICK_DIV cycles later.

Structure
REQ-027 The shared package holds the in_word field offsets and widths, the FSM state enumeration, and the paddle clamp limits 1 and 6.
REQ-028 One sub-module, game_tick_gen (TICK_DIV counter with tick output), is instantiated; all other logic stays in game_engine.

Verification
REQ-029 All scenarios below use TICK_DIV=4 and SERVE_HOLD=2.
REQ-030 Release reset -> in_word=12'h6DB, held unchanged; first PLAY movement after 3 ticks gives ball column 4, row 4.
REQ-031 p1_up held for 5 ticks from reset -> paddle-1 centre goes 3,2,1,1,1; p1_up and p1_dn together -> no move.
REQ-032 Ball at row 7 with dy=0 -> next tick row 6, dy=1.
REQ-033 Ball at column 6, row 5, dx=0, paddle-2 centre 4 -> next tick column 5, dx=1; same case with paddle-2 centre 1 -> column 7, score1 increments, FSM goes to POINT.
REQ-034 WIN_SCORE=1, one miss -> game_over=1 one tick after POINT and in_word frozen; start on a tick -> scores 0, FSM SERVE.
REQ-035 rst pulsed mid-PLAY -> every output at its REQ-025 value within the same cycle.
